// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game logic.
// Grid geometry, block coordinates, FSM states, move directions.
package maze_pkg;

  localparam int MAZE_COLS  = 40;
  localparam int MAZE_ROWS  = 30;
  localparam int ROM_ADDR_W = 11;

  typedef logic [5:0] bcoord_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    READ,
    WAIT,
    WIN
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

endpackage

// File: rtl/move_pacer.sv
// Free-running move pacing counter.
// Pulses tick on the last count of each TICKS-cycle period.
module move_pacer #(
  parameter int TICKS = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count while enabled, wrap at LAST, hold at zero otherwise
  always_ff @(posedge clk) begin
    if (rst || clr || !en)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/maze_move_ctrl.sv
// Player movement controller for the block maze.
// Paces moves, checks target blocks in the maze ROM, flags a win.
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int          MOVE_TICKS = 25000000,
  parameter logic [15:0] FREE_VALUE = 16'hFFFF,
  parameter int          START_BCOL = 1,
  parameter int          START_BROW = 1,
  parameter int          EXIT_BCOL  = 38,
  parameter int          EXIT_BROW  = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_win,
  output logic [15:0] o_move_cnt
);

  localparam bcoord_t ST_C   = bcoord_t'(START_BCOL);
  localparam bcoord_t ST_R   = bcoord_t'(START_BROW);
  localparam bcoord_t EX_C   = bcoord_t'(EXIT_BCOL);
  localparam bcoord_t EX_R   = bcoord_t'(EXIT_BROW);
  localparam bcoord_t LAST_C = bcoord_t'(MAZE_COLS - 1);
  localparam bcoord_t LAST_R = bcoord_t'(MAZE_ROWS - 1);

  state_t  state;
  bcoord_t col, row;
  bcoord_t tcol, trow;
  bcoord_t nxt_col, nxt_row;
  dir_t    dir;
  logic    any_btn;
  logic    off_grid;
  logic    run;
  logic    tick;

  assign run = (state == PLAY) || (state == READ) || (state == WAIT);

  move_pacer #(
    .TICKS (MOVE_TICKS)
  ) u_pacer (
    .clk  (clk),
    .rst  (rst),
    .clr  (i_start),
    .en   (run),
    .tick (tick)
  );

  assign o_player_bcol = col;
  assign o_player_brow = row;
  assign o_exit_bcol   = EX_C;
  assign o_exit_brow   = EX_R;

  // Pick direction by priority and form the neighbouring target block
  always_comb begin
    any_btn  = i_up | i_down | i_left | i_right;
    dir      = DIR_RIGHT;
    nxt_col  = col;
    nxt_row  = row;
    off_grid = 1'b0;
    if (i_up)
      dir = DIR_UP;
    else if (i_down)
      dir = DIR_DOWN;
    else if (i_left)
      dir = DIR_LEFT;
    unique case (dir)
      DIR_UP: begin
        off_grid = (row == '0);
        nxt_row  = row - 1'b1;
      end
      DIR_DOWN: begin
        off_grid = (row >= LAST_R);
        nxt_row  = row + 1'b1;
      end
      DIR_LEFT: begin
        off_grid = (col == '0);
        nxt_col  = col - 1'b1;
      end
      DIR_RIGHT: begin
        off_grid = (col >= LAST_C);
        nxt_col  = col + 1'b1;
      end
    endcase
  end

  // Game FSM: move attempt, ROM wall check, position and win update
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= ST_C;
      row        <= ST_R;
      tcol       <= '0;
      trow       <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      o_win      <= 1'b0;
      o_move_cnt <= '0;
    end else if (i_start) begin
      state      <= PLAY;
      col        <= ST_C;
      row        <= ST_R;
      o_rom_en   <= 1'b0;
      o_win      <= 1'b0;
      o_move_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        PLAY: begin
          if (tick && any_btn && !off_grid) begin
            tcol       <= nxt_col;
            trow       <= nxt_row;
            o_rom_en   <= 1'b1;
            o_rom_addr <= {nxt_col, nxt_row[4:0]};
            state      <= READ;
          end
        end
        READ: begin
          o_rom_en <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          state <= PLAY;
          if (i_rom_data == FREE_VALUE) begin
            col <= tcol;
            row <= trow;
            if (o_move_cnt != 16'hFFFF)
              o_move_cnt <= o_move_cnt + 1'b1;
            if (tcol == EX_C && trow == EX_R) begin
              state <= WIN;
              o_win <= 1'b1;
            end
          end
        end
        WIN: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl with a ROM model and read scoreboard.
// Second instance uses a nearby exit to exercise the win path.
module tb_maze_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, up, down, left, right;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [5:0]  pcol, prow, ecol, erow;
  logic        win;
  logic [15:0] mcnt;

  logic        b_start, b_right, zero;
  logic        b_rom_en;
  logic [10:0] b_rom_addr;
  logic [15:0] b_rom_data;
  logic [5:0]  b_pcol, b_prow, b_ecol, b_erow;
  logic        b_win;
  logic [15:0] b_mcnt;

  int errors = 0;
  int checks = 0;
  int n_reads = 0;
  int unexp = 0;
  int b_reads = 0;
  int cc, cr, exp_cnt, r0;
  logic [10:0] exp_q[$];
  bit wall [0:63][0:31];

  maze_move_ctrl #(
    .MOVE_TICKS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_up          (up),
    .i_down        (down),
    .i_left        (left),
    .i_right       (right),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_player_bcol (pcol),
    .o_player_brow (prow),
    .o_exit_bcol   (ecol),
    .o_exit_brow   (erow),
    .o_win         (win),
    .o_move_cnt    (mcnt)
  );

  maze_move_ctrl #(
    .MOVE_TICKS (4),
    .EXIT_BCOL  (3),
    .EXIT_BROW  (1)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .i_start       (b_start),
    .i_up          (zero),
    .i_down        (zero),
    .i_left        (zero),
    .i_right       (b_right),
    .o_rom_en      (b_rom_en),
    .o_rom_addr    (b_rom_addr),
    .i_rom_data    (b_rom_data),
    .o_player_bcol (b_pcol),
    .o_player_brow (b_prow),
    .o_exit_bcol   (b_ecol),
    .o_exit_brow   (b_erow),
    .o_win         (b_win),
    .o_move_cnt    (b_mcnt)
  );

  always @(posedge clk)
    if (rom_en)
      rom_data <= wall[rom_addr[10:5]][rom_addr[4:0]] ? 16'h7FFF : 16'hFFFF;

  always @(posedge clk)
    if (b_rom_en)
      b_rom_data <= wall[b_rom_addr[10:5]][b_rom_addr[4:0]] ? 16'h7FFF : 16'hFFFF;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rom_en === 1'b1) begin
      n_reads++;
      if (exp_q.size() > 0)
        chk("rom_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
      else
        unexp++;
    end
  end

  always @(negedge clk)
    if (b_rom_en === 1'b1)
      b_reads++;

  task automatic pos(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(pcol), c);
    chk({tag, "_row"}, 32'(prow), r);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_en === 1'b1)
        break;
    end
    chk("rom_en_seen", 32'(rom_en), 1);
  endtask

  task automatic step_move(input logic [3:0] btn, input int tc, input int tr,
                           input int nc, input int nr, input string tag);
    {up, down, left, right} = btn;
    exp_q.push_back({6'(tc), 5'(tr)});
    wait_en();
    {up, down, left, right} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    pos(tag, nc, nr);
  endtask

  task automatic go(input logic [3:0] btn, input int n);
    int dc, dr;
    dc = btn[0] ? 1 : (btn[1] ? -1 : 0);
    dr = btn[3] ? -1 : (btn[2] ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      step_move(btn, cc + dc, cr + dr, cc + dc, cr + dr, "walk");
      cc += dc;
      cr += dr;
      exp_cnt++;
    end
    chk("walk_cnt", 32'(mcnt), exp_cnt);
  endtask

  task automatic hold(input logic [3:0] btn, input int n);
    {up, down, left, right} = btn;
    repeat (n) @(negedge clk);
    {up, down, left, right} = 4'b0000;
  endtask

  task automatic edge_hold(input logic [3:0] btn, input string tag);
    r0 = n_reads;
    hold(btn, 16);
    chk({tag, "_reads"}, n_reads, r0);
    pos(tag, cc, cr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    {up, down, left, right} = 4'b0000;
    b_start = 1'b0;
    b_right = 1'b0;
    zero = 1'b0;
    repeat (3) @(negedge clk);

    pos("rst", 1, 1);
    chk("rst_exit_col", 32'(ecol), 38);
    chk("rst_exit_row", 32'(erow), 28);
    chk("rst_win", 32'(win), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_cnt", 32'(mcnt), 0);
    chk("rst_b_win", 32'(b_win), 0);

    rst = 1'b0;
    r0 = n_reads;
    hold(4'b0001, 12);
    chk("idle_reads", n_reads, r0);
    pos("idle", 1, 1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    right = 1'b1;
    exp_q.push_back({6'd2, 5'd1});
    wait_en();
    right = 1'b0;
    @(negedge clk);
    chk("t1_rom_en_one", 32'(rom_en), 0);
    pos("t1_wait", 1, 1);
    @(negedge clk);
    pos("t1_move", 2, 1);
    chk("t1_cnt", 32'(mcnt), 1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pos("restart", 1, 1);
    chk("restart_cnt", 32'(mcnt), 0);
    wall[1][0] = 1'b1;
    r0 = n_reads;
    step_move(4'b1000, 1, 0, 1, 1, "wall");
    chk("wall_cnt", 32'(mcnt), 0);
    chk("wall_reads", n_reads, r0 + 1);

    cc = 1;
    cr = 1;
    exp_cnt = 0;
    go(4'b0001, 4);
    go(4'b0100, 4);
    step_move(4'b1001, 5, 4, 5, 4, "up_right");
    cr = 4;
    exp_cnt++;
    chk("up_right_cnt", 32'(mcnt), exp_cnt);

    go(4'b0010, 5);
    go(4'b0100, 1);
    edge_hold(4'b0010, "edge_left");
    go(4'b0001, 39);
    edge_hold(4'b0001, "edge_right");
    go(4'b0100, 24);
    edge_hold(4'b0100, "edge_down");
    chk("walk_total", 32'(mcnt), 78);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    right = 1'b1;
    exp_q.push_back({6'd2, 5'd1});
    wait_en();
    right = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pos("abort", 1, 1);
    chk("abort_cnt", 32'(mcnt), 0);
    @(negedge clk);
    @(negedge clk);
    pos("abort_late", 1, 1);
    step_move(4'b0001, 2, 1, 2, 1, "abort_play");
    chk("abort_play_cnt", 32'(mcnt), 1);

    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_right = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_win === 1'b1)
        break;
    end
    chk("win_flag", 32'(b_win), 1);
    chk("win_col", 32'(b_pcol), 3);
    chk("win_row", 32'(b_prow), 1);
    chk("win_cnt", 32'(b_mcnt), 2);
    chk("win_reads", b_reads, 2);
    chk("win_exit_col", 32'(b_ecol), 3);
    repeat (16) @(negedge clk);
    chk("win_hold_reads", b_reads, 2);
    chk("win_hold_col", 32'(b_pcol), 3);
    chk("win_hold_flag", 32'(b_win), 1);
    b_right = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("win_restart_flag", 32'(b_win), 0);
    chk("win_restart_col", 32'(b_pcol), 1);
    chk("win_restart_row", 32'(b_prow), 1);
    chk("win_restart_cnt", 32'(b_mcnt), 0);

    right = 1'b1;
    exp_q.push_back({6'd3, 5'd1});
    wait_en();
    right = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_read_en", 32'(rom_en), 0);
    pos("rst_read", 1, 1);
    chk("rst_read_cnt", 32'(mcnt), 0);
    rst = 1'b0;
    r0 = n_reads;
    hold(4'b0001, 12);
    chk("rst_idle_reads", n_reads, r0);
    pos("rst_idle", 1, 1);

    chk("unexpected_reads", unexp, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
